// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester arbiter serialising operations onto one shared combinational ALU
module alu_arbiter #(
    parameter int unsigned ALU_WAIT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [2:0] req0_op,
    input  logic [7:0] req0_a,
    input  logic [7:0] req0_b,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [2:0] req1_op,
    input  logic [7:0] req1_a,
    input  logic [7:0] req1_b,
    output logic       resp_valid,
    input  logic       resp_ready,
    output logic       resp_id,
    output logic [7:0] resp_y,
    output logic [7:0] alu_opcode,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    input  logic [7:0] alu_y,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_RESP
    } state_t;

    localparam logic [3:0] WAIT_LOAD = 4'(ALU_WAIT);

    state_t     state;
    state_t     state_nxt;
    logic       prio;
    logic [3:0] wait_cnt;
    logic       grant0;
    logic       grant1;
    logic       take0;
    logic       take1;
    logic       xfer;
    logic       cnt_last;

    // prio only breaks ties; a lone valid requester is always granted
    assign grant0   = req0_valid && (!req1_valid || !prio);
    assign grant1   = req1_valid && (!req0_valid || prio);
    assign take0    = req0_valid && req0_ready;
    assign take1    = req1_valid && req1_ready;
    assign xfer     = take0 || take1;
    assign cnt_last = (wait_cnt == 4'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (xfer)       state_nxt = ST_EXEC;
            ST_EXEC: if (cnt_last)   state_nxt = ST_RESP;
            ST_RESP: if (resp_ready) state_nxt = ST_IDLE;
            default:                 state_nxt = ST_IDLE;
        endcase
    end

    // readies are gated by rst so nothing is offered while reset is held
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        busy       = (state != ST_IDLE);
        if (state == ST_IDLE && !rst) begin
            req0_ready = grant0;
            req1_ready = grant1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio       <= 1'b0;
            resp_valid <= 1'b0;
            resp_id    <= 1'b0;
            resp_y     <= 8'h00;
            alu_opcode <= 8'h00;
            alu_a      <= 8'h00;
            alu_b      <= 8'h00;
            wait_cnt   <= 4'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (xfer) begin
                        alu_opcode <= {5'b00000, take1 ? req1_op : req0_op};
                        alu_a      <= take1 ? req1_a : req0_a;
                        alu_b      <= take1 ? req1_b : req0_b;
                        resp_id    <= take1;
                        wait_cnt   <= WAIT_LOAD;
                    end
                end
                ST_EXEC: begin
                    wait_cnt <= wait_cnt - 4'd1;
                    if (cnt_last) begin
                        resp_y     <= alu_y;
                        resp_valid <= 1'b1;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        prio       <= ~resp_id;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed and randomized checks of alu_arbiter (ALU_WAIT 1 and 4) against a behavioural model
module tb_alu_arbiter;

    typedef struct packed {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
    } req_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] v0;
    logic [1:0] v1;
    logic [1:0] rr;
    logic [2:0] op0 [2];
    logic [2:0] op1 [2];
    logic [7:0] a0 [2];
    logic [7:0] b0 [2];
    logic [7:0] a1 [2];
    logic [7:0] b1 [2];
    logic [1:0] rdy0;
    logic [1:0] rdy1;
    logic [1:0] rv;
    logic [1:0] rid;
    logic [1:0] bsy;
    logic [7:0] ry  [2];
    logic [7:0] aop [2];
    logic [7:0] aa  [2];
    logic [7:0] ab  [2];
    logic [7:0] ay  [2];

    int         n_checks = 0;
    int         n_fail = 0;
    bit         rnd_mode = 1'b0;
    req_t       rq [4][$];
    logic [8:0] rlog [2][$];
    bit         acc [4];
    int         lat [2];
    int         xfer_at [2];
    bit         rv_prev [2];
    int         tcyc = 0;

    // model state: one pending operation per instance, tracked by edge timestamps
    bit         m_busy [2];
    bit         m_done [2];
    bit         m_prio [2];
    bit         m_id [2];
    bit [2:0]   m_op [2];
    bit [7:0]   m_a [2];
    bit [7:0]   m_b [2];
    bit [7:0]   m_y [2];
    int         m_due [2];
    int         m_edge = 0;

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_fn(input logic [7:0] opc, input logic [7:0] a, input logic [7:0] b);
        case (opc)
            8'd0:    return a + b;
            8'd1:    return a - b;
            8'd2:    return a & b;
            8'd3:    return a | b;
            8'd4:    return a ^ b;
            8'd5:    return ~(a & b);
            8'd6:    return a << b[2:0];
            8'd7:    return a >> b[2:0];
            default: return 8'hee;
        endcase
    endfunction

    function automatic bit [1:0] grant(input bit va, input bit vb, input bit p);
        if (va && (!vb || !p)) return 2'b01;
        if (vb && (!va || p))  return 2'b10;
        return 2'b00;
    endfunction

    function automatic int wait_of(input int k);
        return (k == 0) ? 1 : 4;
    endfunction

    for (genvar k = 0; k < 2; k++) begin : g_dut
        assign ay[k] = alu_fn(aop[k], aa[k], ab[k]);
        alu_arbiter #(.ALU_WAIT(k == 0 ? 1 : 4)) u_dut (
            .clk        (clk),
            .rst        (rst),
            .req0_valid (v0[k]),
            .req0_ready (rdy0[k]),
            .req0_op    (op0[k]),
            .req0_a     (a0[k]),
            .req0_b     (b0[k]),
            .req1_valid (v1[k]),
            .req1_ready (rdy1[k]),
            .req1_op    (op1[k]),
            .req1_a     (a1[k]),
            .req1_b     (b1[k]),
            .resp_valid (rv[k]),
            .resp_ready (rr[k]),
            .resp_id    (rid[k]),
            .resp_y     (ry[k]),
            .alu_opcode (aop[k]),
            .alu_a      (aa[k]),
            .alu_b      (ab[k]),
            .alu_y      (ay[k]),
            .busy       (bsy[k])
        );
    end

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h at t=%0t", nm, k, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            tcyc++;
        end
    end

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                for (int k = 0; k < 2; k++) begin
                    m_busy[k] = 1'b0; m_done[k] = 1'b0; m_prio[k] = 1'b0; m_id[k] = 1'b0;
                    m_op[k] = 3'd0; m_a[k] = 8'd0; m_b[k] = 8'd0; m_y[k] = 8'd0;
                end
            end else begin
                m_edge++;
                for (int k = 0; k < 2; k++) begin
                    bit [1:0] g;
                    g = grant(v0[k], v1[k], m_prio[k]);
                    if (!m_busy[k]) begin
                        if (g != 2'b00) begin
                            m_id[k]   = g[1];
                            m_op[k]   = g[1] ? op1[k] : op0[k];
                            m_a[k]    = g[1] ? a1[k]  : a0[k];
                            m_b[k]    = g[1] ? b1[k]  : b0[k];
                            m_busy[k] = 1'b1;
                            m_due[k]  = m_edge + wait_of(k);
                        end
                    end else if (!m_done[k]) begin
                        if (m_edge == m_due[k]) begin
                            m_done[k] = 1'b1;
                            m_y[k]    = alu_fn({5'b00000, m_op[k]}, m_a[k], m_b[k]);
                        end
                    end else if (rr[k]) begin
                        m_done[k] = 1'b0;
                        m_busy[k] = 1'b0;
                        m_prio[k] = !m_id[k];
                    end
                end
            end
        end
    end

    // compare process: DUT outputs against the model at every falling edge
    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                bit [1:0] g;
                bit       idle_ok;
                g       = grant(v0[k], v1[k], m_prio[k]);
                idle_ok = !rst && !m_busy[k];
                chk("req0_ready", k, 32'(rdy0[k]), 32'(idle_ok && g[0]));
                chk("req1_ready", k, 32'(rdy1[k]), 32'(idle_ok && g[1]));
                chk("busy", k, 32'(bsy[k]), 32'(m_busy[k]));
                chk("resp_valid", k, 32'(rv[k]), 32'(m_done[k]));
                chk("resp_id", k, 32'(rid[k]), 32'(m_id[k]));
                chk("resp_y", k, 32'(ry[k]), 32'(m_y[k]));
                chk("alu_opcode", k, 32'(aop[k]), 32'({5'b00000, m_op[k]}));
                chk("alu_a", k, 32'(aa[k]), 32'(m_a[k]));
                chk("alu_b", k, 32'(ab[k]), 32'(m_b[k]));
                acc[2*k]   = v0[k] && rdy0[k] && !rst;
                acc[2*k+1] = v1[k] && rdy1[k] && !rst;
                if (acc[2*k] || acc[2*k+1]) xfer_at[k] = tcyc + 1;
                if (rv[k] && !rv_prev[k]) lat[k] = tcyc - xfer_at[k];
                rv_prev[k] = rv[k];
                if (rv[k] && rr[k] && !rst) rlog[k].push_back({rid[k], ry[k]});
            end
        end
    end

    // drivers: present queue heads, pop on accepted transfers, random junk when idle
    initial begin
        v0 = 2'b00;
        v1 = 2'b00;
        for (int k = 0; k < 2; k++) begin
            op0[k] = 3'd0; a0[k] = 8'd0; b0[k] = 8'd0;
            op1[k] = 3'd0; a1[k] = 8'd0; b1[k] = 8'd0;
        end
        forever begin
            @(posedge clk);
            #1;
            for (int k = 0; k < 2; k++) begin
                req_t r;
                for (int n = 0; n < 2; n++) begin
                    if (acc[2*k+n] && rq[2*k+n].size() > 0) void'(rq[2*k+n].pop_front());
                    acc[2*k+n] = 1'b0;
                end
                v0[k] = (rq[2*k].size() > 0) && (!rnd_mode || $urandom_range(0, 3) != 0);
                r = v0[k] ? rq[2*k][0] : req_t'(19'($urandom));
                op0[k] = r.op; a0[k] = r.a; b0[k] = r.b;
                v1[k] = (rq[2*k+1].size() > 0) && (!rnd_mode || $urandom_range(0, 3) != 0);
                r = v1[k] ? rq[2*k+1][0] : req_t'(19'($urandom));
                op1[k] = r.op; a1[k] = r.a; b1[k] = r.b;
            end
        end
    end

    task automatic sync();
        @(posedge clk);
        #3;
    endtask

    task automatic push(input int k, input int n, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        req_t r;
        r.op = op; r.a = a; r.b = b;
        rq[2*k+n].push_back(r);
    endtask

    function automatic logic [8:0] log_at(input int k, input int i);
        if (i < rlog[k].size()) return rlog[k][i];
        return 9'h1ff;
    endfunction

    task automatic wait_log(input int k, input int n, input int bound);
        int t = 0;
        while (rlog[k].size() < n && t < bound) begin
            sync();
            t++;
        end
        chk("wait_log", k, 32'(rlog[k].size() >= n), 32'd1);
    endtask

    task automatic wait_flag(input string nm, input int k, input bit want_rv, input int bound);
        int t = 0;
        while (!(want_rv ? rv[k] : bsy[k]) && t < bound) begin
            sync();
            t++;
        end
        chk(nm, k, 32'(want_rv ? rv[k] : bsy[k]), 32'd1);
    endtask

    task automatic wait_idle(input int bound);
        int t = 0;
        while ((bsy != 2'b00 || rq[0].size() + rq[1].size() + rq[2].size() + rq[3].size() != 0) && t < bound) begin
            sync();
            t++;
        end
        chk("wait_idle", 0, 32'(bsy == 2'b00), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1);
    end

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        rr  = 2'b00;
        rst = 1'b1;
        repeat (3) sync();
        for (int k = 0; k < 2; k++) begin
            chk("rst_resp_valid", k, 32'(rv[k]), 32'd0);
            chk("rst_resp_y", k, 32'(ry[k]), 32'd0);
            chk("rst_alu_opcode", k, 32'(aop[k]), 32'd0);
            chk("rst_busy", k, 32'(bsy[k]), 32'd0);
        end

        // single operation on both latencies
        rst = 1'b0;
        rr  = 2'b11;
        sync();
        push(0, 0, 3'd0, 8'h12, 8'h34);
        push(1, 0, 3'd0, 8'h12, 8'h34);
        wait_log(0, 1, 20);
        wait_log(1, 1, 20);
        chk("single_y", 0, 32'(log_at(0, 0)), 32'h046);
        chk("single_y", 1, 32'(log_at(1, 0)), 32'h046);
        chk("latency", 0, 32'(lat[0]), 32'd1);
        chk("latency", 1, 32'(lat[1]), 32'd4);
        chk("single_opcode", 0, 32'(aop[0]), 32'h00);
        chk("single_alu_a", 1, 32'(aa[1]), 32'h12);

        // contention from reset, twice
        wait_idle(50);
        rst = 1'b1;
        sync();
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            rlog[k].delete();
            push(k, 0, 3'd0, 8'd1, 8'd1);
            push(k, 1, 3'd0, 8'd2, 8'd2);
        end
        for (int k = 0; k < 2; k++) wait_log(k, 2, 60);
        for (int k = 0; k < 2; k++) begin
            chk("contend_first", k, 32'(log_at(k, 0)), 32'h002);
            chk("contend_second", k, 32'(log_at(k, 1)), 32'h104);
            push(k, 0, 3'd0, 8'd3, 8'd3);
            push(k, 1, 3'd0, 8'd5, 8'd5);
        end
        for (int k = 0; k < 2; k++) wait_log(k, 4, 60);
        for (int k = 0; k < 2; k++) begin
            chk("contend_third", k, 32'(log_at(k, 2)), 32'h006);
            chk("contend_fourth", k, 32'(log_at(k, 3)), 32'h10a);
        end

        // backpressure on instance 0
        wait_idle(50);
        rlog[0].delete();
        rr = 2'b10;
        push(0, 1, 3'd0, 8'd7, 8'd8);
        wait_flag("bp_resp_valid", 0, 1'b1, 20);
        push(0, 0, 3'd0, 8'd3, 8'd3);
        repeat (5) begin
            chk("bp_resp_y", 0, 32'(ry[0]), 32'h0f);
            chk("bp_resp_id", 0, 32'(rid[0]), 32'd1);
            chk("bp_alu_a", 0, 32'(aa[0]), 32'h07);
            chk("bp_ready0", 0, 32'(rdy0[0]), 32'd0);
            chk("bp_ready1", 0, 32'(rdy1[0]), 32'd0);
            sync();
        end
        rr = 2'b11;
        sync();
        chk("bp_complete", 0, 32'(rv[0]), 32'd0);
        wait_log(0, 2, 30);
        chk("bp_first", 0, 32'(log_at(0, 0)), 32'h10f);
        chk("bp_second", 0, 32'(log_at(0, 1)), 32'h006);

        // reset during EXEC on the ALU_WAIT=4 instance
        wait_idle(50);
        rlog[1].delete();
        push(1, 0, 3'd0, 8'd9, 8'd9);
        wait_flag("exec_busy", 1, 1'b0, 20);
        sync();
        rst = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("mid_rst_busy", k, 32'(bsy[k]), 32'd0);
            chk("mid_rst_resp_y", k, 32'(ry[k]), 32'd0);
            chk("mid_rst_alu_a", k, 32'(aa[k]), 32'd0);
            chk("mid_rst_resp_valid", k, 32'(rv[k]), 32'd0);
        end
        sync();
        rst = 1'b0;
        repeat (10) sync();
        chk("discarded", 1, 32'(rlog[1].size()), 32'd0);
        push(1, 0, 3'd0, 8'd4, 8'd4);
        wait_log(1, 1, 30);
        chk("after_rst", 1, 32'(log_at(1, 0)), 32'h008);

        // opcode sweep on requester 1
        wait_idle(50);
        rlog[0].delete();
        push(0, 1, 3'd1, 8'd5, 8'd7);
        wait_log(0, 1, 20);
        chk("op1_literal", 0, 32'(log_at(0, 0)), 32'h1fe);
        for (int op = 0; op < 8; op++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            for (int k = 0; k < 2; k++) begin
                rlog[k].delete();
                push(k, 1, 3'(op), ra, rb);
            end
            for (int k = 0; k < 2; k++) begin
                wait_log(k, 1, 30);
                chk("op_sweep", k, 32'(log_at(k, 0)), 32'({1'b1, alu_fn(8'(op), ra, rb)}));
            end
        end

        // randomized traffic with cancels, backpressure and occasional resets
        rnd_mode = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            rr  = 2'($urandom);
            rst = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < 4; i++) begin
                if (rq[i].size() < 2 && $urandom_range(0, 3) == 0) rq[i].push_back(req_t'(19'($urandom)));
            end
            sync();
        end
        rst      = 1'b0;
        rnd_mode = 1'b0;
        rr       = 2'b11;
        wait_idle(300);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: ALU_WAIT, 1, number of clock cycles the ALU inputs are held before alu_y is captured; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 req0_valid  input  1  requester 0 has an operation pending.
REQ-005 req0_ready  output  1  arbiter accepts requester 0 this cycle.
REQ-006 req0_op  input  3  requester 0 opcode.
REQ-007 req0_a, req0_b  input  8 each  requester 0 operands.
REQ-008 req1_valid, req1_ready, req1_op, req1_a, req1_b  same widths/meanings for requester 1.
REQ-009 resp_valid  output  1  result available.
REQ-010 resp_ready  input  1  consumer takes the result.
REQ-011 resp_id  output  1  requester that owns the result.
REQ-012 resp_y  output  8  result value.
REQ-013 alu_opcode  output  8  to ALU opcode port: {5'b0, op}.
REQ-014 alu_a, alu_b  output  8 each  to ALU operand ports.
REQ-015 alu_y  input  8  from ALU result port; combinational in alu_opcode/alu_a/alu_b.
REQ-016 busy  output  1  high in any state other than IDLE.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, EXEC, RESP.
REQ-018 IDLE: reqN_ready SHALL be 1 only for the granted requester; both SHALL be 0 in EXEC and RESP.
REQ-019 Grant: only one valid -> that requester; both valid -> requester equal to priority pointer prio; neither -> no ready.
REQ-020 A transfer occurs on an edge where reqN_valid and reqN_ready are both 1; the block SHALL register op, a, b and N into alu_opcode, alu_a, alu_b and resp_id, load wait counter with ALU_WAIT, and go to EXEC.
REQ-021 alu_opcode, alu_a, alu_b SHALL stay constant from the transfer edge until the edge leaving RESP.
REQ-022 EXEC: the counter SHALL decrement each edge; on the edge where it reaches 0, resp_y SHALL capture alu_y, resp_valid SHALL go to 1, and the state SHALL go to RESP.
REQ-023 Latency: resp_valid SHALL be high exactly ALU_WAIT edges after the transfer edge.
REQ-024 RESP: resp_valid, resp_y and resp_id SHALL hold while resp_ready=0.
REQ-025 On an edge with resp_valid=1 and resp_ready=1, the block SHALL clear resp_valid, set prio to the inverse of resp_id, and return to IDLE. A new request SHALL be accepted no earlier than the following edge.
REQ-026 A requester's inputs are ignored when it is not granted; valid dropping before the transfer SHALL cancel the grant without state change.
REQ-027 resp_y SHALL hold its last value after leaving RESP until the next capture.
REQ-028 The priority pointer SHALL change only on response completion, never on idle cycles.

Reset
REQ-029 While rst=1: state IDLE, prio 0, resp_valid 0, resp_id 0, resp_y 0, alu_opcode/alu_a/alu_b 0, counter 0, busy 0, req0_ready and req1_ready 0.
REQ-030 Reset asserted in EXEC or RESP SHALL discard the in-flight operation with no response; after deassertion, the first grant with both valid SHALL go to requester 0.

Verification (bench uses the team ALU, or a stub with alu_y = alu_a + alu_b)
REQ-031 Single op, ALU_WAIT=1, stub ALU: req0 op=0 a=8'h12 b=8'h34, resp_ready=1 -> resp_valid 1 edge after transfer, resp_y=8'h46, resp_id=0, alu_opcode=8'h00.
REQ-032 Contention: both valid from reset, req0 a=1 b=1, req1 a=2 b=2 -> responses in order id0 y=2, then id1 y=4; next simultaneous pair is granted to requester 0 first again.
REQ-033 Backpressure: resp_ready=0 for 5 cycles in RESP -> resp_valid, resp_y, resp_id and ALU outputs stable; both readies 0; completion on the first edge with resp_ready=1.
REQ-034 ALU_WAIT=4: transfer at edge E -> resp_valid first high after edge E+4; alu_a/alu_b unchanged over E..E+4.
REQ-035 Reset mid-EXEC: assert rst one cycle after transfer -> no resp_valid ever for that op; all outputs 0 during reset; the next request completes normally.
REQ-036 Opcode sweep: req1 op 0..7 with random a, b, team ALU -> each resp_y equals the ALU output for {5'b0, op}, a, b.
